// File: rtl/icache_assoc_pkg.sv
// Shared encodings and parameter defaults for the set-associative instruction cache.
// AXI burst/size/response codes and the refill controller state type live here.
package icache_assoc_pkg;

    localparam int DEF_WAYS       = 2;
    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2
    } state_t;

    // Way-index width that stays at least one bit for direct-mapped builds.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag, valid and data storage with a combinational read port.
// Valid bits reset; tag and data arrays are plain storage without reset.
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int TAG_W      = 20,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    localparam int IDX_W     = $clog2(SETS),
    localparam int OFF_W     = $clog2(LINE_WORDS)
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IDX_W-1:0]      rd_idx,
    input  logic [OFF_W-1:0]      rd_off,
    output logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [OFF_W-1:0]      wr_off,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  line_we,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic                  line_valid,
    input  logic                  inval_all
);

    logic [DATA_WIDTH-1:0] data_q [SETS*LINE_WORDS];
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [SETS-1:0]       valid_q;

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
    assign rd_data  = data_q[{rd_idx, rd_off}];

    always_ff @(posedge clk) begin
        if (wr_en)
            data_q[{wr_idx, wr_off}] <= wr_data;
        if (line_we)
            tag_q[wr_idx] <= line_tag;
    end

    // Flush wins over a same-cycle line update so nothing survives an invalidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (inval_all)
            valid_q <= '0;
        else if (line_we)
            valid_q[wr_idx] <= line_valid;
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with AXI4 wrapping refill and early restart.
// Hits answer combinationally in IDLE; misses fetch critical-word-first.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS       = DEF_WAYS,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_req,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_err,
    input  logic                  flush,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    output logic [7:0]            mem_arlen,
    output logic [2:0]            mem_arsize,
    output logic [1:0]            mem_arburst,
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    input  logic [31:0]           mem_rdata,
    input  logic [1:0]            mem_rresp,
    input  logic                  mem_rlast,
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W - 2;
    localparam int WAY_W  = clog2_min1(WAYS);
    localparam int BEAT_W = OFF_W + 1;

    state_t                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]    fill_addr;
    logic [WAY_W-1:0]         fill_way;
    logic [BEAT_W-1:0]        beat_cnt;
    logic                     fill_bad, first_beat, flush_pend;
    logic [SETS-1:0][WAY_W-1:0] rr_q;
    logic [31:0]              hits_q, misses_q;

    logic [OFF_W-1:0] req_off, fill_off;
    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0] req_tag, fill_tag;

    assign req_off  = cpu_addr[2 +: OFF_W];
    assign req_idx  = cpu_addr[OFF_W+2 +: IDX_W];
    assign req_tag  = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign fill_off = fill_addr[2 +: OFF_W];
    assign fill_idx = fill_addr[OFF_W+2 +: IDX_W];
    assign fill_tag = fill_addr[ADDR_WIDTH-1 -: TAG_W];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[1:0], fill_addr[1:0]};

    logic [WAYS-1:0][TAG_W-1:0]      way_tag;
    logic [WAYS-1:0]                 way_valid;
    logic [WAYS-1:0][DATA_WIDTH-1:0] way_data;
    logic [WAYS-1:0]                 way_wr_en, way_line_we;

    logic hit_take, miss_take, flush_now, beat_fire, fill_done;
    logic beat_in_line, line_ok, inval_all;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way #(
            .SETS       (SETS),
            .LINE_WORDS (LINE_WORDS),
            .TAG_W      (TAG_W),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_way (
            .clk        (clk),
            .rst_n      (rst_n),
            .rd_idx     (req_idx),
            .rd_off     (req_off),
            .rd_tag     (way_tag[w]),
            .rd_valid   (way_valid[w]),
            .rd_data    (way_data[w]),
            .wr_en      (way_wr_en[w]),
            .wr_idx     (fill_idx),
            .wr_off     (fill_off + beat_cnt[OFF_W-1:0]),
            .wr_data    (mem_rdata),
            .line_we    (way_line_we[w]),
            .line_tag   (fill_tag),
            .line_valid (line_ok),
            .inval_all  (inval_all)
        );
    end

    logic [WAYS-1:0]       hit_vec;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;
    logic [WAY_W-1:0]      victim;
    logic                  found_free;

    always_comb begin
        hit_data   = '0;
        victim     = rr_q[req_idx];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
            if (hit_vec[w])
                hit_data = way_data[w];
            if (!found_free && !way_valid[w]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end
    assign hit = |hit_vec;

    always_comb begin
        state_d     = state_q;
        cpu_ready   = 1'b0;
        cpu_err     = 1'b0;
        cpu_rdata   = hit_data;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        hit_take    = 1'b0;
        miss_take   = 1'b0;
        flush_now   = 1'b0;
        beat_fire   = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    flush_now = 1'b1;
                end else if (cpu_req) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        hit_take  = 1'b1;
                    end else begin
                        miss_take = 1'b1;
                        state_d   = ST_AR;
                    end
                end
            end
            ST_AR: begin
                mem_arvalid = 1'b1;
                if (mem_arready)
                    state_d = ST_R;
            end
            ST_R: begin
                mem_rready = 1'b1;
                if (mem_rvalid) begin
                    beat_fire = 1'b1;
                    if (first_beat) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = mem_rdata;
                        cpu_err   = (mem_rresp != AXI_RESP_OKAY);
                    end
                    if (mem_rlast) begin
                        fill_done = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Beats past the line length are dropped; the exact count is checked at rlast.
    assign beat_in_line = (beat_cnt != BEAT_W'(LINE_WORDS));
    assign line_ok      = fill_done && !fill_bad && (mem_rresp == AXI_RESP_OKAY)
                          && !flush_pend && !flush
                          && (beat_cnt == BEAT_W'(LINE_WORDS-1));
    assign inval_all    = flush_now || (fill_done && (flush_pend || flush));

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            way_wr_en[w]   = beat_fire && beat_in_line && (fill_way == WAY_W'(w));
            way_line_we[w] = fill_done && (fill_way == WAY_W'(w));
        end
    end

    assign mem_araddr  = {fill_addr[ADDR_WIDTH-1:2], 2'b00};
    assign mem_arlen   = 8'(LINE_WORDS-1);
    assign mem_arsize  = AXI_SIZE_4B;
    assign mem_arburst = AXI_BURST_WRAP;
    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

    always_ff @(posedge clk) begin
        if (miss_take) begin
            fill_addr <= cpu_addr;
            fill_way  <= victim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beat_cnt   <= '0;
            fill_bad   <= 1'b0;
            first_beat <= 1'b0;
            flush_pend <= 1'b0;
            rr_q       <= '0;
            hits_q     <= '0;
            misses_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hit_take)
                hits_q <= hits_q + 32'd1;
            if (miss_take) begin
                misses_q   <= misses_q + 32'd1;
                beat_cnt   <= '0;
                fill_bad   <= 1'b0;
                first_beat <= 1'b1;
            end
            if (beat_fire) begin
                first_beat <= 1'b0;
                if (beat_in_line)
                    beat_cnt <= beat_cnt + 1'b1;
                if (mem_rresp != AXI_RESP_OKAY)
                    fill_bad <= 1'b1;
            end
            if (state_q != ST_IDLE && flush)
                flush_pend <= 1'b1;
            if (fill_done)
                flush_pend <= 1'b0;
            if (line_ok)
                rr_q[fill_idx] <= (rr_q[fill_idx] == WAY_W'(WAYS-1)) ? '0
                                                                      : rr_q[fill_idx] + 1'b1;
        end
    end

endmodule
